// File: rtl/mod5_wrap_tracker.sv
// Extends a mod-5 up/down counter with NDIG upper base-5 digits by watching its wrap events.
// Optional SEG7_OUT_EN adds a registered active-low seven-segment bus covering every digit.
module mod5_wrap_tracker #(
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              R,
    input  logic              en,
    input  logic              clr,
    input  logic              M,
    input  logic [3:0]        lo_digit,
    output logic [3*NDIG-1:0] hi_digits,
    output logic              carry_out,
    output logic              borrow_out,
    output logic              ovf,
`ifdef SEG7_OUT_EN
    output logic [7*(NDIG+1)-1:0] seg,
`endif
    output logic              err
);

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t            state;
    logic [2:0]        prev_lo;
    logic [2:0]        cur_lo;
    logic              cur_legal;
    logic              wrap_up;
    logic              wrap_down;
    logic [3*NDIG-1:0] hi_inc;
    logic [3*NDIG-1:0] hi_dec;
    logic              inc_carry;
    logic              dec_borrow;
    logic              unused_lo_bit3;

    assign cur_lo         = lo_digit[2:0];
    assign cur_legal      = (cur_lo <= 3'd4);
    assign unused_lo_bit3 = lo_digit[3];

    assign wrap_up   = (state == TRACK) &&  M && (prev_lo == 3'd4) && (cur_lo == 3'd0);
    assign wrap_down = (state == TRACK) && !M && (prev_lo == 3'd0) && (cur_lo == 3'd4);

    // Ripple both neighbours of hi_digits; the final carry/borrow means every digit wrapped.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        hi_inc     = hi_digits;
        hi_dec     = hi_digits;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int k = 0; k < NDIG; k++) begin
            if (inc_carry) begin
                if (hi_digits[3*k +: 3] == 3'd4) begin
                    hi_inc[3*k +: 3] = 3'd0;
                end else begin
                    hi_inc[3*k +: 3] = hi_digits[3*k +: 3] + 3'd1;
                    inc_carry        = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (hi_digits[3*k +: 3] == 3'd0) begin
                    hi_dec[3*k +: 3] = 3'd4;
                end else begin
                    hi_dec[3*k +: 3] = hi_digits[3*k +: 3] - 3'd1;
                    dec_borrow       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (R || clr) begin
            state      <= SYNC;
            prev_lo    <= 3'd0;
            hi_digits  <= '0;
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
            err        <= 1'b0;
        end else if (!en) begin
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
        end else if (!cur_legal) begin
            state      <= SYNC;
            err        <= 1'b1;
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
        end else begin
            state      <= TRACK;
            prev_lo    <= cur_lo;
            carry_out  <= wrap_up && inc_carry;
            borrow_out <= wrap_down && dec_borrow;
            if (wrap_up) begin
                hi_digits <= hi_inc;
                if (inc_carry) ovf <= 1'b1;
            end else if (wrap_down) begin
                hi_digits <= hi_dec;
                if (dec_borrow) ovf <= 1'b1;
            end
        end
    end

`ifdef SEG7_OUT_EN
    function automatic logic [6:0] seg7(input logic [2:0] d);
        case (d)
            3'd0:    seg7 = 7'b1000000;
            3'd1:    seg7 = 7'b1111001;
            3'd2:    seg7 = 7'b0100100;
            3'd3:    seg7 = 7'b0110000;
            3'd4:    seg7 = 7'b0011001;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // lo_q is captured alongside hi_digits so all fields lag their digits by the same cycle.
    logic [2:0]             lo_q;
    logic [7*(NDIG+1)-1:0]  seg_next;

    always_comb begin
        seg_next      = '1;
        seg_next[6:0] = seg7(lo_q);
        for (int k = 0; k < NDIG; k++) begin
            seg_next[7*(k+1) +: 7] = seg7(hi_digits[3*k +: 3]);
        end
    end

    always_ff @(posedge clk) begin
        if (R || clr) begin
            lo_q <= 3'd7;
            seg  <= '1;
        end else begin
            if (en) lo_q <= cur_lo;
            seg <= seg_next;
        end
    end
`endif

endmodule

// File: tb/tb_mod5_wrap_tracker.sv
// Directed self-checking bench for mod5_wrap_tracker (NDIG=2); seg fields checked when SEG7_OUT_EN is set.
module tb_mod5_wrap_tracker;

    localparam int NDIG = 2;

    logic              clk = 1'b0;
    logic              R   = 1'b0;
    logic              en  = 1'b0;
    logic              clr = 1'b0;
    logic              M   = 1'b0;
    logic [3:0]        lo_digit = 4'd0;
    logic [3*NDIG-1:0] hi_digits;
    logic              carry_out;
    logic              borrow_out;
    logic              ovf;
    logic              err;
`ifdef SEG7_OUT_EN
    logic [7*(NDIG+1)-1:0] seg;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mod5_wrap_tracker #(.NDIG(NDIG)) dut (
        .clk        (clk),
        .R          (R),
        .en         (en),
        .clr        (clr),
        .M          (M),
        .lo_digit   (lo_digit),
        .hi_digits  (hi_digits),
        .carry_out  (carry_out),
        .borrow_out (borrow_out),
        .ovf        (ovf),
`ifdef SEG7_OUT_EN
        .seg        (seg),
`endif
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample 1 ns after the edge.
    task automatic step(input logic [3:0] l, input logic m, input logic e,
                        input logic c, input logic r);
        lo_digit = l;
        M        = m;
        en       = e;
        clr      = c;
        R        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        #2;
        // 1. Reset, then first up-wrap
        do_reset();
        check("rst_hi", hi_digits, 6'o00);
        check("rst_carry", carry_out, 1'b0);
        check("rst_borrow", borrow_out, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_err", err, 1'b0);
        for (int v = 0; v <= 4; v++) begin
            step(4'(v), 1'b1, 1'b1, 1'b0, 1'b0);
            check("up_pre_hi", hi_digits, 6'o00);
        end
        step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("up1_hi", hi_digits, 6'o01);
        check("up1_carry", carry_out, 1'b0);

        // 2. Walk to 24 wraps (4,4) then overflow on the 25th
        for (int w = 0; w < 23; w++) begin
            step(4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
            step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        check("w24_hi", hi_digits, 6'o44);
        check("w24_carry", carry_out, 1'b0);
        check("w24_ovf", ovf, 1'b0);
        step(4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("w25_hi", hi_digits, 6'o00);
        check("w25_carry", carry_out, 1'b1);
        check("w25_ovf", ovf, 1'b1);
        step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("w25_pulse_end", carry_out, 1'b0);
        check("w25_ovf_sticky", ovf, 1'b1);

        // 3. Down-wrap from zero underflows to 4,4
        do_reset();
        step(4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("dn_pre_hi", hi_digits, 6'o00);
        step(4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        check("dn_hi", hi_digits, 6'o44);
        check("dn_borrow", borrow_out, 1'b1);
        check("dn_ovf", ovf, 1'b1);
        step(4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        check("dn_pulse_end", borrow_out, 1'b0);
        check("dn_hold1_hi", hi_digits, 6'o44);
        step(4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        check("dn_hold2_hi", hi_digits, 6'o44);

        // 4. Illegal code in TRACK, then resync before counting again
        do_reset();
        step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ill_err", err, 1'b1);
        check("ill_hi", hi_digits, 6'o00);
        step(4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ill_resync_hi", hi_digits, 6'o00);
        step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ill_after_hi", hi_digits, 6'o01);
        check("ill_err_sticky", err, 1'b1);

        // 5. clr in a wrap cycle beats the increment
        do_reset();
        step(4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_pre_err", err, 1'b1);
        step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int w = 0; w < 3; w++) begin
            step(4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
            step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        check("clr_pre_hi", hi_digits, 6'o03);
        step(4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        step(4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_hi", hi_digits, 6'o00);
        check("clr_carry", carry_out, 1'b0);
        check("clr_ovf", ovf, 1'b0);
        check("clr_err", err, 1'b0);
        step(4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_resync_hi", hi_digits, 6'o01);

        // 6. en=0 hides a 4->0, previous sample is held; then R mid-count
        step(4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        step(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_hi", hi_digits, 6'o01);
        check("hold_carry", carry_out, 1'b0);
        step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("hold_resume_hi", hi_digits, 6'o02);
        step(4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        check("midrst_hi", hi_digits, 6'o00);
        check("midrst_ovf", ovf, 1'b0);
        check("midrst_err", err, 1'b0);

`ifdef SEG7_OUT_EN
        check("seg_rst", seg, 21'h1FFFFF);
        step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        step(4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        check("seg_012", seg, {7'b1000000, 7'b1111001, 7'b0100100});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
